// File: rtl/poly_tone_gen.sv
// Polyphonic tone generator: per-voice phase accumulators and linear envelopes feed a
// two-stage multiply/mix pipeline whose saturated sum is strobed out at the sample rate.
module poly_tone_gen #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned GAIN_SHIFT = 4,
    parameter int unsigned ENV_DIV    = 196,
    parameter int unsigned SAMPLE_DIV = 1042
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_VOICES*PHASE_W-1:0]   freq_words,
    input  logic [NUM_VOICES-1:0]           gates,
    input  logic [1:0]                      wave_sel,
    output logic [SAMPLE_W-1:0]             sample_out,
    output logic                            sample_valid,
    output logic [NUM_VOICES-1:0]           voice_active
);

    localparam int unsigned EnvCntW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam int unsigned SmpCntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned ProdW   = 24;
    localparam int unsigned SumW    = ProdW + $clog2(NUM_VOICES) + 1 + GAIN_SHIFT;
    localparam int unsigned WideW   = ((SumW > SAMPLE_W) ? SumW : SAMPLE_W) + 1;

    localparam logic [EnvCntW-1:0] EnvLast = EnvCntW'(ENV_DIV - 1);
    localparam logic [SmpCntW-1:0] SmpLast = SmpCntW'(SAMPLE_DIV - 1);

    localparam logic signed [WideW-1:0] SatMax =
        {{(WideW - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [WideW-1:0] SatMin = ~SatMax;

    localparam logic [1:0] WaveSquare = 2'b00;
    localparam logic [1:0] WaveSaw    = 2'b01;
    localparam logic [1:0] WaveTri    = 2'b10;

    logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]      phase_d [NUM_VOICES];
    logic [7:0]              env_q   [NUM_VOICES];
    logic [7:0]              env_d   [NUM_VOICES];
    logic signed [ProdW-1:0] prod_q  [NUM_VOICES];
    logic signed [ProdW-1:0] prod_d  [NUM_VOICES];

    logic signed [SAMPLE_W-1:0] mix_q, mix_d;
    logic [EnvCntW-1:0]         env_cnt_q, env_cnt_d;
    logic [SmpCntW-1:0]         smp_cnt_q, smp_cnt_d;
    logic [SAMPLE_W-1:0]        sample_out_q, sample_out_d;
    logic                       sample_valid_q, sample_valid_d;
    logic [NUM_VOICES-1:0]      voice_active_q, voice_active_d;

    logic                       env_tick;
    logic                       smp_wrap;
    logic signed [WideW-1:0]    sum_w;
    logic signed [WideW-1:0]    shifted_w;

    // top holds phase[PHASE_W-1 -: 17]: msb followed by the 16-bit u field.
    function automatic logic signed [15:0] wave_value(input logic [16:0] top,
                                                      input logic [1:0]  sel);
        logic [15:0]        u;
        logic signed [15:0] w;
        u = top[15:0];
        w = '0;
        case (sel)
            WaveSquare: w = top[16] ? 16'sh8001 : 16'sh7FFF;
            WaveSaw:    w = {~top[16], top[15:1]};
            WaveTri:    w = top[16] ? (16'h7FFF - u) : (u - 16'h8000);
            default:    w = '0;
        endcase
        return w;
    endfunction

    function automatic logic signed [ProdW-1:0] scale(input logic signed [15:0] w,
                                                      input logic [7:0]         env);
        logic signed [ProdW-1:0] a;
        logic signed [ProdW-1:0] b;
        a = {{(ProdW - 16){w[15]}}, w};
        b = {{(ProdW - 8){1'b0}}, env};
        return a * b;
    endfunction

    always_comb begin
        env_tick  = (env_cnt_q == EnvLast);
        env_cnt_d = env_tick ? '0 : env_cnt_q + 1'b1;
        smp_wrap  = (smp_cnt_q == SmpLast);
        smp_cnt_d = smp_wrap ? '0 : smp_cnt_q + 1'b1;
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            // A silent, ungated voice parks at phase 0 so the next note starts coherently.
            if (!gates[v] && (env_q[v] == 8'd0)) begin
                phase_d[v] = '0;
            end else begin
                phase_d[v] = phase_q[v] + freq_words[v*PHASE_W +: PHASE_W];
            end

            env_d[v] = env_q[v];
            if (env_tick) begin
                if (gates[v]) begin
                    if (env_q[v] != 8'hFF) env_d[v] = env_q[v] + 8'd1;
                end else if (env_q[v] != 8'd0) begin
                    env_d[v] = env_q[v] - 8'd1;
                end
            end

            voice_active_d[v] = (env_d[v] != 8'd0);
            prod_d[v] = scale(wave_value(phase_q[v][PHASE_W-1 -: 17], wave_sel), env_q[v]);
        end
    end

    always_comb begin
        sum_w = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum_w = sum_w + {{(WideW - ProdW){prod_q[v][ProdW-1]}}, prod_q[v]};
        end
        // WideW leaves headroom for the shift, so the clamp sees the exact value.
        shifted_w = sum_w <<< GAIN_SHIFT;
        if (shifted_w > SatMax) begin
            mix_d = SatMax[SAMPLE_W-1:0];
        end else if (shifted_w < SatMin) begin
            mix_d = SatMin[SAMPLE_W-1:0];
        end else begin
            mix_d = shifted_w[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        sample_valid_d = smp_wrap;
        sample_out_d   = smp_wrap ? mix_q : sample_out_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                env_q[v]   <= '0;
                prod_q[v]  <= '0;
            end
            mix_q          <= '0;
            env_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            voice_active_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                env_q[v]   <= env_d[v];
                prod_q[v]  <= prod_d[v];
            end
            mix_q          <= mix_d;
            env_cnt_q      <= env_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            voice_active_q <= voice_active_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign voice_active = voice_active_q;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: three parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus directed corner sequences.
module tb_poly_tone_gen;

    localparam int NV = 8;
    localparam longint VSQ  = 64'sd133689360;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic            clock;
    logic            reset;
    logic [NV*32-1:0] freq_words;
    logic [NV-1:0]   gates;
    logic [1:0]      wave_sel;
    logic [31:0]     so [3];
    logic            sv [3];
    logic [7:0]      va [3];

    int checks = 0;
    int errors = 0;

    // A: defaults. B: fast envelope, every-cycle output. C: as B with large gain.
    poly_tone_gen u_dut_a (
        .clock(clock), .reset(reset), .freq_words(freq_words), .gates(gates),
        .wave_sel(wave_sel), .sample_out(so[0]), .sample_valid(sv[0]), .voice_active(va[0])
    );
    poly_tone_gen #(.ENV_DIV(1), .SAMPLE_DIV(1), .GAIN_SHIFT(4)) u_dut_b (
        .clock(clock), .reset(reset), .freq_words(freq_words), .gates(gates),
        .wave_sel(wave_sel), .sample_out(so[1]), .sample_valid(sv[1]), .voice_active(va[1])
    );
    poly_tone_gen #(.ENV_DIV(1), .SAMPLE_DIV(1), .GAIN_SHIFT(8)) u_dut_c (
        .clock(clock), .reset(reset), .freq_words(freq_words), .gates(gates),
        .wave_sel(wave_sel), .sample_out(so[2]), .sample_valid(sv[2]), .voice_active(va[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int ed_p [3] = '{196, 1, 1};
    int sd_p [3] = '{1042, 1, 1};
    int g_p  [3] = '{4, 4, 8};

    longint m_phase [3][NV];
    int     m_env   [3][NV];
    longint m_psum  [3];
    longint m_mix   [3];
    longint m_out   [3];
    int     m_valid [3];
    longint m_k     [3];

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] ph;
        longint      exp_out;
    } vec_t;
    vec_t tbl [11];

    function automatic longint wave_of(longint ph, logic [1:0] sel);
        longint u;
        bit     msb;
        u   = (ph / 32768) % 65536;
        msb = (ph >= 64'sd2147483648);
        case (sel)
            2'b00:   return msb ? -32767 : 32767;
            2'b01:   return (ph / 65536) - 32768;
            2'b10:   return msb ? (32767 - u) : (u - 32768);
            default: return 0;
        endcase
    endfunction

    function automatic longint clamp(longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    task automatic model_step();
        for (int n = 0; n < 3; n++) begin
            if (reset) begin
                m_k[n] = 0; m_psum[n] = 0; m_mix[n] = 0; m_out[n] = 0; m_valid[n] = 0;
                for (int v = 0; v < NV; v++) begin
                    m_phase[n][v] = 0;
                    m_env[n][v]   = 0;
                end
            end else begin
                longint psum;
                bit     tick;
                tick = ((m_k[n] % ed_p[n]) == ed_p[n] - 1);
                m_valid[n] = ((m_k[n] % sd_p[n]) == sd_p[n] - 1) ? 1 : 0;
                if (m_valid[n] != 0) m_out[n] = m_mix[n];
                m_mix[n] = clamp(m_psum[n] * (64'sd1 << g_p[n]));
                psum = 0;
                for (int v = 0; v < NV; v++) psum += wave_of(m_phase[n][v], wave_sel) * m_env[n][v];
                m_psum[n] = psum;
                for (int v = 0; v < NV; v++) begin
                    if (!gates[v] && m_env[n][v] == 0) m_phase[n][v] = 0;
                    else m_phase[n][v] = (m_phase[n][v] + longint'(freq_words[v*32 +: 32]))
                                         % 64'sd4294967296;
                    if (tick) begin
                        if (gates[v] && m_env[n][v] < 255) m_env[n][v]++;
                        else if (!gates[v] && m_env[n][v] > 0) m_env[n][v]--;
                    end
                end
                m_k[n]++;
            end
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        for (int n = 0; n < 3; n++) begin
            logic [7:0] exp_va;
            exp_va = '0;
            for (int v = 0; v < NV; v++) exp_va[v] = (m_env[n][v] != 0);
            chk($sformatf("model_out%0d", n), longint'($signed(so[n])), m_out[n]);
            chk($sformatf("model_valid%0d", n), longint'(sv[n]), longint'(m_valid[n]));
            chk($sformatf("model_active%0d", n), longint'(va[n]), longint'(exp_va));
        end
        for (int v = 0; v < NV; v++)
            chk($sformatf("model_phase_b%0d", v), longint'(u_dut_b.phase_q[v]), m_phase[1][v]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int     strobes;
        int     last;
        int     cnt;
        int     e;
        longint s;
        longint maxv;
        longint minv;

        reset = 1'b1; gates = '0; wave_sel = 2'b00; freq_words = '0;
        tbl[0]  = '{2'b00, 32'h0000_0000,  VSQ};
        tbl[1]  = '{2'b00, 32'h8000_0000, -VSQ};
        tbl[2]  = '{2'b01, 32'h0000_0000, -64'sd133693440};
        tbl[3]  = '{2'b01, 32'hC000_0000,  64'sd66846720};
        tbl[4]  = '{2'b01, 32'hFFFF_0000,  VSQ};
        tbl[5]  = '{2'b10, 32'h0000_0000, -64'sd133693440};
        tbl[6]  = '{2'b10, 32'h8000_0000,  VSQ};
        tbl[7]  = '{2'b10, 32'h4000_0000,  64'sd0};
        tbl[8]  = '{2'b10, 32'hC000_0000, -64'sd4080};
        tbl[9]  = '{2'b10, 32'h2000_0000, -64'sd66846720};
        tbl[10] = '{2'b11, 32'h1234_5678,  64'sd0};

        do_reset();
        chk("reset_out_a", longint'(so[0]), 0);
        chk("reset_active_b", longint'(va[1]), 0);

        // Idle: no gates, strobe period on the default divider.
        for (int v = 0; v < NV; v++) freq_words[v*32 +: 32] = $urandom;
        strobes = 0;
        last = -1;
        for (int c = 0; c < 5000; c++) begin
            cycle();
            if (sv[0]) begin
                if (last >= 0) chk("strobe_period", c - last, 1042);
                last = c;
                strobes++;
                chk("idle_out", longint'(so[0]), 0);
            end
        end
        chk("strobe_count", strobes, 4);
        chk("idle_active", longint'(va[0]), 0);

        // Wave shapes at a frozen phase with full envelope.
        for (int r = 0; r < 11; r++) begin
            do_reset();
            wave_sel = tbl[r].sel;
            freq_words = '0;
            freq_words[31:0] = tbl[r].ph;
            gates = 8'h01;
            cycle();
            freq_words = '0;
            repeat (261) cycle();
            chk($sformatf("tbl_out%0d", r), longint'($signed(so[1])), tbl[r].exp_out);
            chk($sformatf("tbl_active%0d", r), longint'(va[1]), 1);
            repeat (8) cycle();
            chk($sformatf("tbl_hold%0d", r), longint'($signed(so[1])), tbl[r].exp_out);
        end

        // Attack to 255 with a square wave, then alternating output.
        do_reset();
        wave_sel = 2'b00;
        freq_words = '0;
        freq_words[31:0] = 32'h1000_0000;
        gates = 8'h01;
        repeat (254) cycle();
        chk("env_254", longint'(u_dut_b.env_q[0]), 254);
        cycle();
        chk("env_255", longint'(u_dut_b.env_q[0]), 255);
        chk("attack_active", longint'(va[1][0]), 1);
        repeat (4) cycle();
        e = 259;
        for (int i = 0; i < 32; i++) begin
            cycle();
            e++;
            s = (((e - 3) % 16) >= 8) ? -VSQ : VSQ;
            chk($sformatf("square_alt%0d", i), longint'($signed(so[1])), s);
        end

        // Release: decay length, then phase parks at 0.
        gates = 8'h00;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (va[1][0] == 1'b1 && cnt < 300);
        chk("decay_len", cnt, 255);
        cycle();
        chk("phase_parked", longint'(u_dut_b.phase_q[0]), 0);

        // All voices in phase with high gain: both clamp rails.
        do_reset();
        for (int v = 0; v < NV; v++) freq_words[v*32 +: 32] = 32'h1000_0000;
        gates = 8'hFF;
        repeat (260) cycle();
        maxv = 0;
        minv = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            s = longint'($signed(so[2]));
            if (s > maxv) maxv = s;
            if (s < minv) minv = s;
        end
        chk("sat_max", maxv, SMAX);
        chk("sat_min", minv, SMIN);

        // One-clock reset while three voices sound.
        gates = 8'h07;
        repeat (20) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("rst_out%0d", n), longint'(so[n]), 0);
            chk($sformatf("rst_valid%0d", n), longint'(sv[n]), 0);
            chk($sformatf("rst_active%0d", n), longint'(va[n]), 0);
        end
        cycle();
        chk("restart_b", longint'(va[1]), 7);
        chk("restart_c", longint'(va[2]), 7);
        repeat (194) cycle();
        chk("restart_a_pre", longint'(va[0]), 0);
        cycle();
        chk("restart_a_tick", longint'(va[0]), 7);

        // Randomised traffic against the model.
        do_reset();
        for (int v = 0; v < NV; v++)
            freq_words[v*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        gates = 8'($urandom);
        wave_sel = 2'($urandom);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) gates[$urandom_range(0, NV - 1)] ^= 1'b1;
            if (c % 500 == 0) wave_sel = 2'($urandom);
            if (c % 1000 == 999) freq_words[$urandom_range(0, NV - 1)*32 +: 32] = $urandom;
            reset = ($urandom_range(0, 1999) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_tone_gen.md
POLY_TONE_GEN -- requirements
Module: poly_tone_gen

Interface
REQ-001 Parameter NUM_VOICES, default 8, number of independent voices.
REQ-002 Parameter PHASE_W, default 32, phase accumulator and frequency word width.
REQ-003 Parameter SAMPLE_W, default 32, signed mixed-sample width.
REQ-004 Parameter GAIN_SHIFT, default 4, left shift applied to the voice sum before saturation.
REQ-005 Parameter ENV_DIV, default 196, clocks per envelope tick.
REQ-006 Parameter SAMPLE_DIV, default 1042, clocks per output sample strobe.
REQ-007 clock  in  1  system clock; all logic rising-edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 freq_words  in  NUM_VOICES*PHASE_W  per-voice phase increment; voice i at bits [i*PHASE_W +: PHASE_W].
REQ-010 gates  in  NUM_VOICES  per-voice note gate.
REQ-011 wave_sel  in  2  00 square, 01 sawtooth, 10 triangle, 11 mute; shared by all voices.
REQ-012 sample_out  out  SAMPLE_W  signed mixed sample, held between strobes.
REQ-013 sample_valid  out  1  one-cycle strobe when sample_out updates.
REQ-014 voice_active  out  NUM_VOICES  bit i high while voice i envelope is nonzero.

Function
REQ-015 Per voice, phase accumulates freq_word every clock, modulo 2^PHASE_W.
REQ-016 Phase of voice i is cleared to 0 when gates[i]=0 and env[i]=0, giving a coherent restart on the next gate.
REQ-017 Wave value is 16-bit signed from u = phase[PHASE_W-2 -: 16] and msb = phase[PHASE_W-1].
REQ-018 Square: +32767 when msb=0, -32767 when msb=1.
REQ-019 Sawtooth: phase[PHASE_W-1 -: 16] with bit 15 inverted.
REQ-020 Triangle: msb=0 -> u-32768; msb=1 -> 32767-u (16-bit wrap).
REQ-021 Mute: wave value 0 for all voices; phases and envelopes keep running.
REQ-022 Envelope per voice is 8-bit unsigned, 0..255, updated only on the shared tick (every ENV_DIV clocks).
REQ-023 On tick: gate high and env<255 -> env+1; gate low and env>0 -> env-1; otherwise hold.
REQ-024 Gate released mid-attack starts the decay from the current env; gate re-asserted mid-decay resumes the attack from the current env.
REQ-025 Pipeline stage 1 registers product wave*env (24-bit signed) per voice.
REQ-026 Pipeline stage 2 registers mix = saturate_SAMPLE_W((sum of products) << GAIN_SHIFT); sum is computed at full width with no intermediate wrap.
REQ-027 Saturation clamps to 2^(SAMPLE_W-1)-1 and -2^(SAMPLE_W-1).
REQ-028 Latency from a phase/env change to mix is 2 clocks.
REQ-029 Sample divider counts 0..SAMPLE_DIV-1 and wraps.
REQ-030 In the cycle after the divider reaches SAMPLE_DIV-1, sample_out <= mix and sample_valid = 1; sample_valid is 0 on all other cycles.
REQ-031 voice_active[i] = (env[i] != 0), registered with env.
REQ-032 freq_word = 0 freezes that voice's phase; output stays constant at the wave value times env.

Reset
REQ-033 While reset is asserted: all phases, envelopes, pipeline registers, both dividers, sample_out, sample_valid and voice_active go to 0 on the next clock edge.
REQ-034 Reset asserted mid-note takes priority over gate and tick activity; no partial update occurs in that cycle.

Verification
REQ-035 Reset, then all gates 0 for 5000 clocks -> sample_out=0, voice_active=0, sample_valid pulses exactly every 1042 clocks.
REQ-036 ENV_DIV=1, voice0 freq=2^28, square, gate0 held -> env reaches 255 after 255 ticks, voice_active[0]=1; mix alternates +133689360/-133689360 every 8 clocks.
REQ-037 Gate0 then dropped -> env reaches 0 after 255 ticks, voice_active[0] falls, phase0 reads 0 on the next cycle.
REQ-038 GAIN_SHIFT=8, all 8 voices square, same freq, env=255 -> sample_out clamps to 2147483647 and -2147483648.
REQ-039 Triangle, freq=2^28, env=255 -> stage-1 product is -32768*255 at phase 0 and 32767*255 at phase 2^31.
REQ-040 Reset pulsed for 1 clock while 3 voices are sounding -> all outputs 0 on the next cycle; attack restarts from env 0.
